// File: rtl/mux_8way_16.sv
// Eight-way word selector: combinational select tree plus a registered copy
// of the selected word and the select code that produced it.
module mux_8way_16 #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [SEL_W-1:0] select,
    output logic [WIDTH-1:0] out,
    input  logic             en,
    output logic [WIDTH-1:0] out_q,
    output logic [SEL_W-1:0] sel_q
);

    logic [WIDTH-1:0] pair_ab, pair_cd, pair_ef, pair_gh;
    logic [WIDTH-1:0] half_lo, half_hi;

    // Binary tree: bit 0 picks within pairs, bit 1 between pairs, bit 2 the half.
    // NOTE: continuous ternary assignments define every select code, so no latch can form.
    assign pair_ab = select[0] ? b : a;
    assign pair_cd = select[0] ? d : c;
    assign pair_ef = select[0] ? f : e;
    assign pair_gh = select[0] ? h : g;

    assign half_lo = select[1] ? pair_cd : pair_ab;
    assign half_hi = select[1] ? pair_gh : pair_ef;

    assign out = select[2] ? half_hi : half_lo;

    // NOTE: non-blocking assignments keep both registers sampling pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= '0;
        end else if (en) begin
            out_q <= out;
            sel_q <= select;
        end
    end

endmodule

// File: tb/tb_mux_8way_16.sv
// Directed and randomized bench for mux_8way_16: vector table for the select
// map, hand sequences for enable hold and async reset, then a random sweep.
module tb_mux_8way_16;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [2:0]  select = 3'b000;
    logic [15:0] w [8];
    logic [15:0] out, out_q;
    logic [2:0]  sel_q;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs [8];

    logic [15:0] exp_out, exp_q;
    logic [2:0]  exp_s;

    always #5 clk = ~clk;

    mux_8way_16 dut (
        .clk    (clk),
        .rst    (rst),
        .a      (w[0]),
        .b      (w[1]),
        .c      (w[2]),
        .d      (w[3]),
        .e      (w[4]),
        .f      (w[5]),
        .g      (w[6]),
        .h      (w[7]),
        .select (select),
        .out    (out),
        .en     (en),
        .out_q  (out_q),
        .sel_q  (sel_q)
    );

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic load_fixed();
        w[0] = 16'b0101010101010101;
        w[1] = 16'b1010101010101010;
        w[2] = 16'b0000000011111111;
        w[3] = 16'b1111111100000000;
        w[4] = 16'b0011001100110011;
        w[5] = 16'b1100110011001100;
        w[6] = 16'b0000111100001111;
        w[7] = 16'b1111000011110000;
    endtask

    initial begin
        vecs[0] = '{3'b000, 16'h5555};
        vecs[1] = '{3'b001, 16'hAAAA};
        vecs[2] = '{3'b010, 16'h00FF};
        vecs[3] = '{3'b011, 16'hFF00};
        vecs[4] = '{3'b100, 16'h3333};
        vecs[5] = '{3'b101, 16'hCCCC};
        vecs[6] = '{3'b110, 16'h0F0F};
        vecs[7] = '{3'b111, 16'hF0F0};

        load_fixed();
        #1;
        check("reset_out_q", out_q, 16'h0000);
        check("reset_sel_q", {13'b0, sel_q}, 16'h0000);

        // Select map, no clock involvement.
        for (int i = 0; i < 8; i++) begin
            select = vecs[i].sel;
            #1;
            check($sformatf("map_sel%0d", i), out, vecs[i].exp);
        end

        // Data sensitivity on the selected and an unselected input.
        select = 3'b101;
        w[5] = 16'hFFFF;
        #1;
        check("sens_selected", out, 16'hFFFF);
        w[0] = 16'h1234;
        #1;
        check("sens_unselected", out, 16'hFFFF);
        load_fixed();

        // Registered load.
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        select = 3'b011;
        @(posedge clk);
        #1;
        check("load_out_q", out_q, 16'hFF00);
        check("load_sel_q", {13'b0, sel_q}, 16'h0003);

        // Enable low holds over two edges while out tracks.
        @(negedge clk);
        en = 1'b0;
        select = 3'b110;
        repeat (2) @(posedge clk);
        #1;
        check("hold_out_q", out_q, 16'hFF00);
        check("hold_sel_q", {13'b0, sel_q}, 16'h0003);
        check("hold_out", out, 16'h0F0F);

        // Async reset between edges, then reset dominating enable.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_q", out_q, 16'h0000);
        check("async_rst_sel_q", {13'b0, sel_q}, 16'h0000);
        check("rst_out_live", out, 16'h0F0F);
        en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dominates_en", out_q, 16'h0000);

        // Release with en=1 loads on the next edge.
        @(negedge clk);
        rst = 1'b0;
        select = 3'b111;
        @(posedge clk);
        #1;
        check("release_out_q", out_q, 16'hF0F0);
        check("release_sel_q", {13'b0, sel_q}, 16'h0007);

        // Random sweep against an index-based reference model.
        exp_q = out_q;
        exp_s = sel_q;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
            select = 3'($urandom_range(7, 0));
            en = 1'($urandom_range(1, 0));
            #1;
            exp_out = w[select];
            check("rand_out", out, exp_out);
            if (en) begin
                exp_q = exp_out;
                exp_s = select;
            end
            @(posedge clk);
            #1;
            check("rand_out_q", out_q, exp_q);
            check("rand_sel_q", {13'b0, sel_q}, {13'b0, exp_s});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
